dl_sequencer: RTL and testbench

- Sequences the HPS download stream into the arcade core.
- Decodes `ioctl_index` into three destinations:
  - ROM bytes (index 0), forwarded through a small FIFO to the ROM write port, which may stall.
  - Game-select byte (index 1).
  - DIP bank (index 254).
- Throttles HPS via `ioctl_wait` and holds the core in reset until all writes have drained, plus a settle period.
- Sits between `hps_io` and the game top; replaces ad hoc `mod`/`sw` latches and `ioctl_download`-driven reset.

---
 rtl/dl_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dl_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dl_sequencer.sv
// HPS download sequencer: routes ROM bytes through a FIFO, latches game-select and DIP bytes,
// and holds the core in reset until writes drain. Optional rom_sum output: DL_SEQUENCER_CHECKSUM_EN.
module dl_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 256,
    parameter int ADDR_W      = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_wr,
    input  logic              rom_ready,
    output logic [7:0]        mod,
    output logic              mod_valid,
    output logic [63:0]       dsw,
    output logic              core_reset,
    output logic              busy
`ifdef DL_SEQUENCER_CHECKSUM_EN
    ,
    output logic [15:0]       rom_sum
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_CNT  = CW'(FIFO_DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN, ST_HOLD} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W+7:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr, r_rptr;
    logic [CW-1:0]       r_count, w_count_nxt;
    logic [HW-1:0]       r_hold;
    logic                r_wait;
    logic [7:0]          r_mod;
    logic                r_mod_valid;
    logic [63:0]         r_dsw;
    logic                w_wr_rom, w_push, w_pop, w_drained;

    assign w_wr_rom  = ioctl_wr && (ioctl_index == 8'd0);
    assign w_push    = w_wr_rom && (r_count != FULL_CNT);
    assign rom_wr    = (r_count != '0);
    assign w_pop     = rom_wr && rom_ready;
    assign w_drained = (r_count == '0) && !w_wr_rom;

    assign rom_addr   = r_mem[r_rptr][ADDR_W+7:8];
    assign rom_data   = r_mem[r_rptr][7:0];
    assign ioctl_wait = r_wait;
    assign mod        = r_mod;
    assign mod_valid  = r_mod_valid;
    assign dsw        = r_dsw;
    assign busy       = core_reset;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wait  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_wait  <= (w_count_nxt >= WAIT_CNT);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        core_reset  = 1'b1;
        case (r_state)
            ST_RUN: begin
                core_reset = 1'b0;
                if (ioctl_download) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ioctl_download)  w_state_nxt = ST_LOAD;
                else if (w_drained)  w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (ioctl_download)     w_state_nxt = ST_LOAD;
                else if (r_hold == '0)  w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    // Counter is parked at its load value outside HOLD, so every HOLD entry starts a full period.
    always_ff @(posedge clk_sys) begin
        if (reset || r_state != ST_HOLD) begin
            r_hold <= HOLD_LOAD;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_mod       <= 8'hFF;
            r_mod_valid <= 1'b0;
            r_dsw       <= '0;
        end else if (ioctl_wr) begin
            if (ioctl_index == 8'd1) begin
                r_mod       <= ioctl_dout;
                r_mod_valid <= 1'b1;
            end else if (ioctl_index == 8'd254 && ioctl_addr[24:3] == '0) begin
                r_dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end
        end
    end

`ifdef DL_SEQUENCER_CHECKSUM_EN
    logic [15:0] r_sum;
    assign rom_sum = r_sum;

    always_ff @(posedge clk_sys) begin
        if (reset || (r_state == ST_RUN && ioctl_download)) begin
            r_sum <= '0;
        end else if (w_pop) begin
            r_sum <= r_sum + {8'h00, rom_data};
        end
    end
`endif

endmodule

// File: tb/tb_dl_sequencer.sv
// Scoreboard bench for dl_sequencer: stimulus queues expected ROM writes, a negedge monitor pops them.
module tb_dl_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        rom_ready = 1'b0;
    logic        ioctl_wait, rom_wr, mod_valid, core_reset, busy;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data, mod;
    logic [63:0] dsw;
`ifdef DL_SEQUENCER_CHECKSUM_EN
    logic [15:0] rom_sum;
`endif

    int total = 0;
    int bad = 0;
    logic [23:0] exp_q[$];

    dl_sequencer dut (
        .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_wr(rom_wr), .rom_ready(rom_ready), .mod(mod),
        .mod_valid(mod_valid), .dsw(dsw), .core_reset(core_reset), .busy(busy)
`ifdef DL_SEQUENCER_CHECKSUM_EN
        , .rom_sum(rom_sum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        if (idx == 8'd0) exp_q.push_back({a[15:0], d});
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic count_hold(input string name, input int exp);
        int n = 0;
        while (core_reset && n < 1000) begin
            n++;
            step();
        end
        chk(name, n, exp);
    endtask

    // Monitor: a transfer happens at the next rising edge whenever rom_wr & rom_ready.
    always @(negedge clk) begin : mon
        logic [23:0] e;
        if (!reset && rom_wr && rom_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rom_unexpected actual=%0h required=none", {rom_addr, rom_data});
            end else begin
                e = exp_q.pop_front();
                chk("rom_xfer", {40'd0, rom_addr, rom_data}, {40'd0, e});
            end
        end
    end

    initial begin
        int g;
        int low;
        step();
        step();
        chk("rst_mod", mod, 8'hFF);
        chk("rst_mod_valid", mod_valid, 0);
        chk("rst_dsw", dsw, 0);
        chk("rst_rom_wr", rom_wr, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 1);
        reset = 1'b0;

        // Reset in the middle of a download with three entries queued.
        rom_ready = 1'b0;
        ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) wr_byte(8'd0, 25'h100 + 25'(i), 8'hC0 + 8'(i));
        chk("t1_wait_set", ioctl_wait, 1);
        reset = 1'b1;
        exp_q.delete();
        step();
        chk("t1_rom_wr", rom_wr, 0);
        chk("t1_wait", ioctl_wait, 0);
        chk("t1_core_reset", core_reset, 1);
        reset = 1'b0;
        ioctl_download = 1'b0;
        count_hold("t1_hold", 256);
        chk("t1_busy_low", busy, 0);

        // Streaming download with a ready sink.
        rom_ready = 1'b1;
        ioctl_download = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            wr_byte(8'd0, 25'(i), 8'h10 + 8'(i));
            chk("t2_latency_wr", rom_wr, 1);
            chk("t2_latency_data", rom_data, 8'h10 + 8'(i));
            chk("t2_wait", ioctl_wait, 0);
        end
        step();
        step();
        chk("t2_empty", rom_wr, 0);
        ioctl_download = 1'b0;
        count_hold("t2_hold", 258);

        // Stalled sink: wait asserts at three entries, then everything drains in order.
        rom_ready = 1'b0;
        ioctl_download = 1'b1;
        step();
        wr_byte(8'd0, 25'd0, 8'h10);
        wr_byte(8'd0, 25'd1, 8'h11);
        chk("t3_wait_two", ioctl_wait, 0);
        wr_byte(8'd0, 25'd2, 8'h12);
        chk("t3_wait_three", ioctl_wait, 1);
        chk("t3_head", rom_data, 8'h10);
        rom_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            g = 0;
            while (ioctl_wait && g < 50) begin
                g++;
                step();
            end
            if (g >= 50) chk("t3_wait_timeout", ioctl_wait, 0);
            wr_byte(8'd0, 25'(i), 8'h10 + 8'(i));
        end
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            g++;
            step();
        end
        chk("t3_drained", exp_q.size(), 0);
        ioctl_download = 1'b0;
        count_hold("t3_hold", 258);

        // Side-channel bytes written while the core runs.
        chk("t4_mod_valid_before", mod_valid, 0);
        wr_byte(8'd1, 25'd0, 8'h07);
        chk("t4_mod_first", mod, 8'h07);
        wr_byte(8'd1, 25'h55, 8'h03);
        chk("t4_mod", mod, 8'h03);
        chk("t4_mod_valid", mod_valid, 1);
        chk("t4_wait", ioctl_wait, 0);
        wr_byte(8'd254, 25'd2, 8'hA5);
        wr_byte(8'd254, 25'd9, 8'h77);
        wr_byte(8'd7, 25'd0, 8'h5A);
        chk("t4_dsw", dsw, 64'h0000_0000_00A5_0000);
        chk("t4_mod_kept", mod, 8'h03);
        chk("t4_no_rom", rom_wr, 0);
        wr_byte(8'd254, 25'd7, 8'h3C);
        chk("t4_dsw_top", dsw, 64'h3C00_0000_00A5_0000);
        chk("t4_core_run", core_reset, 0);

        // Download re-asserted part way through HOLD.
        ioctl_download = 1'b1;
        step();
        step();
        ioctl_download = 1'b0;
        low = 0;
        for (int i = 0; i < 157; i++) begin
            if (!core_reset) low++;
            step();
        end
        chk("t5_held", low, 0);
        ioctl_download = 1'b1;
        step();
        step();
        step();
        chk("t5_load_core_reset", core_reset, 1);
        chk("t5_load_busy", busy, 1);
        ioctl_download = 1'b0;
        count_hold("t5_rehold", 258);

`ifdef DL_SEQUENCER_CHECKSUM_EN
        begin
            int s = 0;
            ioctl_download = 1'b1;
            step();
            chk("cs_clear", rom_sum, 0);
            rom_ready = 1'b1;
            for (int i = 0; i < 258; i++) begin
                wr_byte(8'd0, 25'(i), 8'hFF);
                s += 255;
            end
            step();
            step();
            ioctl_download = 1'b0;
            count_hold("cs_hold", 258);
            chk("cs_sum", rom_sum, 16'(s));
            ioctl_download = 1'b1;
            step();
            chk("cs_clear_again", rom_sum, 0);
            ioctl_download = 1'b0;
            count_hold("cs_hold2", 258);
        end
`endif

        chk("end_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
